div_sched: RTL and testbench

- Shares one div_top sequential divider between two requesters, each using a valid/ready request port and a one-cycle response pulse.
- Round-robin arbitration between the two ports.
- Generates the divider start pulse and holds operands stable for the whole operation.
- Detects completion, classifies the result, and guards against a hung divider with a timeout.
- Sits between the datapath clients and the existing div_top instance.

---
 rtl/div_pkg.sv | 18 +
 rtl/rr_arb2.sv | 21 ++
 rtl/div_sched.sv | 167 ++++++++++++++++
 tb/tb_div_sched.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared encodings for the div_top scheduler: status codes, FSM states, default width.
package div_pkg;

    localparam int unsigned DIV_W = 10;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_DVZ = 2'b01;
    localparam logic [1:0] ST_OV  = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester other than last_grant wins.
module rr_arb2 (
    input  logic [1:0] valid_i,
    input  logic       allow_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (allow_i) begin
            unique case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one sequential div_top between two valid/ready requesters, with
// zero-divisor bypass, result classification and a WAIT timeout.
module div_sched
    import div_pkg::*;
#(
    parameter int unsigned W           = DIV_W,
    parameter int unsigned TIMEOUT_CYC = 63,
    parameter int unsigned ZERO_BYPASS = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [W-1:0] rsp_q,
    output logic [1:0]   rsp_status,
    output logic         sched_busy,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic [W-1:0] div_q,
    input  logic         div_busy,
    input  logic         div_valid,
    input  logic         div_ov,
    input  logic         div_dvz
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_e         state_q, state_d;
    logic           last_grant_q, last_grant_d;
    logic           id_q, id_d;
    logic [W-1:0]   div_a_q, div_a_d;
    logic [W-1:0]   div_b_q, div_b_d;
    logic [W-1:0]   rsp_q_q, rsp_q_d;
    logic [1:0]     rsp_status_q, rsp_status_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic           rsp_valid_q, div_start_q, sched_busy_q;

    logic [1:0]     grant;
    logic           allow;
    logic           hs;
    logic           done;
    logic [W-1:0]   sel_a, sel_b;

    // A divider left running across a reset must drain before the next grant.
    assign allow = rst && (state_q == S_IDLE) && !div_busy;

    rr_arb2 u_arb (
        .valid_i      ({req1_valid, req0_valid}),
        .allow_i      (allow),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign hs         = |grant;
    assign sel_a      = grant[1] ? req1_a : req0_a;
    assign sel_b      = grant[1] ? req1_b : req0_b;

    // First WAIT cycle is skipped so a stale valid from the last op is ignored.
    assign done = (wait_cnt_q != '0) && !div_busy && (div_valid || div_ov || div_dvz);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        rsp_q_d      = rsp_q_q;
        rsp_status_d = rsp_status_q;
        wait_cnt_d   = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (hs) begin
                    id_d         = grant[1];
                    last_grant_d = grant[1];
                    if ((ZERO_BYPASS != 0) && (sel_b == '0)) begin
                        rsp_status_d = ST_DVZ;
                        rsp_q_d      = '0;
                        state_d      = S_RESP;
                    end else begin
                        div_a_d = sel_a;
                        div_b_d = sel_b;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q != CNT_W'(TIMEOUT_CYC)) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
                if (done) begin
                    if (div_dvz) begin
                        rsp_status_d = ST_DVZ;
                        rsp_q_d      = '0;
                    end else if (div_ov) begin
                        rsp_status_d = ST_OV;
                        rsp_q_d      = '0;
                    end else begin
                        rsp_status_d = ST_OK;
                        rsp_q_d      = div_q;
                    end
                    state_d = S_RESP;
                end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    rsp_status_d = ST_TMO;
                    rsp_q_d      = '0;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            rsp_q_q      <= '0;
            rsp_status_q <= ST_OK;
            wait_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            div_start_q  <= 1'b0;
            sched_busy_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            rsp_q_q      <= rsp_q_d;
            rsp_status_q <= rsp_status_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_valid_q  <= (state_d == S_RESP);
            div_start_q  <= (state_d == S_ISSUE);
            sched_busy_q <= (state_d != S_IDLE);
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_q      = rsp_q_q;
    assign rsp_status = rsp_status_q;
    assign sched_busy = sched_busy_q;
    assign div_start  = div_start_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural divider per instance
// (normal, stuck-busy, overflow and long-latency modes).
module tb_div_sched;
    import div_pkg::*;

    localparam int unsigned W   = 10;
    localparam int unsigned TMO = 63;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready, rsp_valid, rsp_id, sched_busy;
    logic [W-1:0] rsp_q;
    logic [1:0]   rsp_status;

    logic         x_valid = 1'b0;
    logic [W-1:0] x_a = '0, x_b = '0;
    logic         x_ready0, x_ready1, x_rsp_valid, x_rsp_id, x_busy;
    logic [W-1:0] x_rsp_q;
    logic [1:0]   x_rsp_status;

    // Behavioural divider state, index 0 serves u_dut, index 1 serves u_dut_nb.
    logic [1:0]   m_start, m_busy = '0, m_valid = '0, m_ov = '0, m_dvz = '0;
    logic [W-1:0] m_a [2];
    logic [W-1:0] m_b [2];
    logic [W-1:0] m_q [2] = '{default: '0};
    int           m_cnt [2] = '{default: 0};
    int           mode = 0;

    div_sched #(.W(W), .TIMEOUT_CYC(TMO), .ZERO_BYPASS(1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_status(rsp_status),
        .sched_busy(sched_busy), .div_start(m_start[0]), .div_a(m_a[0]), .div_b(m_b[0]),
        .div_q(m_q[0]), .div_busy(m_busy[0]), .div_valid(m_valid[0]),
        .div_ov(m_ov[0]), .div_dvz(m_dvz[0])
    );

    div_sched #(.W(W), .TIMEOUT_CYC(TMO), .ZERO_BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst),
        .req0_valid(1'b0), .req0_ready(x_ready0), .req0_a('0), .req0_b('0),
        .req1_valid(x_valid), .req1_ready(x_ready1), .req1_a(x_a), .req1_b(x_b),
        .rsp_valid(x_rsp_valid), .rsp_id(x_rsp_id), .rsp_q(x_rsp_q), .rsp_status(x_rsp_status),
        .sched_busy(x_busy), .div_start(m_start[1]), .div_a(m_a[1]), .div_b(m_b[1]),
        .div_q(m_q[1]), .div_busy(m_busy[1]), .div_valid(m_valid[1]),
        .div_ov(m_ov[1]), .div_dvz(m_dvz[1])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (m_start[i]) begin
                m_busy[i]  <= 1'b1;
                m_valid[i] <= 1'b0;
                m_ov[i]    <= 1'b0;
                m_dvz[i]   <= 1'b0;
                m_cnt[i]   <= (i == 0 && mode == 3) ? 20 : 3;
            end else if (m_busy[i] && !(i == 0 && mode == 1)) begin
                if (m_cnt[i] == 0) begin
                    m_busy[i]  <= 1'b0;
                    m_valid[i] <= 1'b1;
                    if (m_b[i] == '0) begin
                        m_dvz[i] <= 1'b1;
                        m_q[i]   <= '1;
                    end else begin
                        m_q[i] <= m_a[i] / m_b[i];
                        if (i == 0 && mode == 2) begin
                            m_ov[i] <= 1'b1;
                            m_q[i]  <= W'(341);
                        end
                    end
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                end
            end
        end
    end

    int cyc = 0, hs_cnt = 0, hs_cyc = 0, rsp_cnt = 0, rsp_cyc = 0;
    int start_cnt = 0, start_cyc = 0, viol = 0, stab_err = 0;
    int x_hs_cnt = 0, x_rsp_cnt = 0, x_start_cnt = 0;
    int last_gnt = 0;
    logic         rsp_id_l = 1'b0, x_id_l = 1'b0, in_op = 1'b0, rsp_prev = 1'b0;
    logic [W-1:0] rsp_q_l = '0, x_q_l = '0, cap_a = '0, cap_b = '0;
    logic [1:0]   rsp_st_l = '0, x_st_l = '0;
    int gnt_log[$];
    int rq_log[$];
    int rid_log[$];

    // Event monitor: handshakes, start pulses, responses and protocol violations.
    always @(negedge clk) begin
        cyc++;
        if (!rst) in_op = 1'b0;
        if (rst && ((req0_valid && req0_ready) || (req1_valid && req1_ready))) begin
            hs_cnt++;
            hs_cyc   = cyc;
            last_gnt = int'(req1_ready);
            gnt_log.push_back(int'(req1_ready));
            if (sched_busy || rsp_valid || m_busy[0]) viol++;
        end
        if ((req0_ready || req1_ready) && (sched_busy || m_busy[0])) viol++;
        if (req0_ready && req1_ready) viol++;
        if (m_start[0]) begin
            start_cnt++;
            start_cyc = cyc;
            in_op     = 1'b1;
            cap_a     = m_a[0];
            cap_b     = m_b[0];
        end else if (in_op && (m_a[0] != cap_a || m_b[0] != cap_b)) begin
            stab_err++;
        end
        if (rsp_valid) begin
            if (rsp_prev) viol++;
            rsp_cnt++;
            rsp_cyc  = cyc;
            rsp_id_l = rsp_id;
            rsp_q_l  = rsp_q;
            rsp_st_l = rsp_status;
            rq_log.push_back(int'(rsp_q));
            rid_log.push_back(int'(rsp_id));
            in_op = 1'b0;
        end
        rsp_prev = rsp_valid;
        if (x_ready0 || (x_ready1 && x_busy)) viol++;
        if (rst && x_valid && x_ready1) x_hs_cnt++;
        if (m_start[1]) x_start_cnt++;
        if (x_rsp_valid) begin
            x_rsp_cnt++;
            x_id_l = x_rsp_id;
            x_q_l  = x_rsp_q;
            x_st_l = x_rsp_status;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 hs, 1 rsp, 2 x_hs, 3 x_rsp
    task automatic wait_for(input int which, input int target, input int budget, input string tag);
        int k;
        int v;
        k = 0;
        v = 0;
        while (k < budget) begin
            v = (which == 0) ? hs_cnt : (which == 1) ? rsp_cnt : (which == 2) ? x_hs_cnt : x_rsp_cnt;
            if (v >= target) break;
            tick(1);
            k++;
        end
        check(tag, 32'(v >= target), 32'd1);
    endtask

    int base;

    initial begin
        tick(2);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy", 32'(sched_busy), 0);
        check("rst_start", 32'(m_start[0]), 0);
        check("rst_div_a", 32'(m_a[0]), 0);
        check("rst_div_b", 32'(m_b[0]), 0);
        check("rst_rsp_q", 32'(rsp_q), 0);
        check("rst_status", 32'(rsp_status), 0);
        check("rst_ready0", 32'(req0_ready), 0);
        rst = 1'b1;
        tick(1);

        // Normal divide through the divider
        req0_a = 10'd175; req0_b = 10'd16; req0_valid = 1'b1;
        wait_for(0, 1, 50, "t1_hs");
        req0_valid = 1'b0;
        wait_for(1, 1, 50, "t1_rsp");
        check("t1_start_lat", 32'(start_cyc - hs_cyc), 1);
        check("t1_start_cnt", 32'(start_cnt), 1);
        check("t1_rsp_lat", 32'(rsp_cyc - start_cyc), 6);
        check("t1_q", 32'(rsp_q_l), 10);
        check("t1_status", 32'(rsp_st_l), 32'(ST_OK));
        check("t1_id", 32'(rsp_id_l), 0);
        check("t1_stable", 32'(stab_err), 0);

        // Zero-divisor bypass
        req1_a = 10'd848; req1_b = 10'd0; req1_valid = 1'b1;
        wait_for(0, 2, 50, "t2_hs");
        req1_valid = 1'b0;
        check("t2_grant", 32'(last_gnt), 1);
        wait_for(1, 2, 50, "t2_rsp");
        check("t2_lat", 32'(rsp_cyc - hs_cyc), 1);
        check("t2_status", 32'(rsp_st_l), 32'(ST_DVZ));
        check("t2_q", 32'(rsp_q_l), 0);
        check("t2_id", 32'(rsp_id_l), 1);
        check("t2_no_start", 32'(start_cnt), 1);

        // Zero divisor without bypass: reported from div_dvz
        x_a = 10'd848; x_b = 10'd0; x_valid = 1'b1;
        wait_for(2, 1, 50, "t2b_hs");
        x_valid = 1'b0;
        wait_for(3, 1, 50, "t2b_rsp");
        check("t2b_start", 32'(x_start_cnt), 1);
        check("t2b_status", 32'(x_st_l), 32'(ST_DVZ));
        check("t2b_q", 32'(x_q_l), 0);
        check("t2b_id", 32'(x_id_l), 1);

        // Both requesters held from reset: round robin
        rst = 1'b0;
        req0_a = 10'd794; req0_b = 10'd8; req0_valid = 1'b1;
        req1_a = 10'd604; req1_b = 10'd8; req1_valid = 1'b1;
        gnt_log.delete(); rq_log.delete(); rid_log.delete();
        tick(2);
        rst = 1'b1;
        base = hs_cnt;
        wait_for(0, base + 4, 200, "t3_hs");
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_for(1, rsp_cnt + ((rq_log.size() < 4) ? 4 - rq_log.size() : 0), 100, "t3_rsp");
        check("t3_nlog", 32'(gnt_log.size()), 4);
        if (gnt_log.size() >= 4 && rq_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                check("t3_grant", 32'(gnt_log[i]), 32'(i % 2));
                check("t3_rsp_q", 32'(rq_log[i]), (i % 2 == 0) ? 32'd99 : 32'd75);
                check("t3_rsp_id", 32'(rid_log[i]), 32'(i % 2));
            end
        end

        // Stuck divider: timeout, then no grant until div_busy falls
        mode = 1;
        base = rsp_cnt;
        req0_a = 10'd100; req0_b = 10'd3; req0_valid = 1'b1;
        wait_for(0, hs_cnt + 1, 50, "t4_hs");
        req0_valid = 1'b0;
        wait_for(1, base + 1, 150, "t4_rsp");
        check("t4_status", 32'(rsp_st_l), 32'(ST_TMO));
        check("t4_q", 32'(rsp_q_l), 0);
        check("t4_lat", 32'(rsp_cyc - start_cyc), TMO + 2);
        base = hs_cnt;
        req1_a = 10'd500; req1_b = 10'd7; req1_valid = 1'b1;
        tick(10);
        check("t4_no_grant", 32'(hs_cnt), 32'(base));
        mode = 0;
        wait_for(0, base + 1, 50, "t4_regrant");
        req1_valid = 1'b0;
        wait_for(1, rsp_cnt + 1, 50, "t4_rsp2");
        check("t4_q2", 32'(rsp_q_l), 71);
        check("t4_id2", 32'(rsp_id_l), 1);
        check("t4_status2", 32'(rsp_st_l), 32'(ST_OK));

        // Overflow flagged together with valid
        mode = 2;
        req0_a = 10'd1000; req0_b = 10'd3; req0_valid = 1'b1;
        wait_for(0, hs_cnt + 1, 50, "t5_hs");
        req0_valid = 1'b0;
        wait_for(1, rsp_cnt + 1, 50, "t5_rsp");
        check("t5_status", 32'(rsp_st_l), 32'(ST_OV));
        check("t5_q", 32'(rsp_q_l), 0);
        mode = 0;

        // Reset in WAIT: op dropped, next grant waits for the divider to drain
        mode = 3;
        req0_a = 10'd300; req0_b = 10'd5; req0_valid = 1'b1;
        wait_for(0, hs_cnt + 1, 50, "t6_hs");
        req0_valid = 1'b0;
        mode = 0;
        tick(3);
        req1_a = 10'd300; req1_b = 10'd5; req1_valid = 1'b1;
        base = rsp_cnt;
        rst = 1'b0;
        #1;
        check("t6_busy", 32'(sched_busy), 0);
        check("t6_start", 32'(m_start[0]), 0);
        check("t6_div_a", 32'(m_a[0]), 0);
        check("t6_div_b", 32'(m_b[0]), 0);
        check("t6_rsp_valid", 32'(rsp_valid), 0);
        check("t6_ready1", 32'(req1_ready), 0);
        tick(2);
        rst = 1'b1;
        wait_for(0, hs_cnt + 1, 200, "t6_regrant");
        req1_valid = 1'b0;
        check("t6_no_rsp", 32'(rsp_cnt), 32'(base));
        wait_for(1, base + 1, 50, "t6_rsp");
        check("t6_q", 32'(rsp_q_l), 60);
        check("t6_id", 32'(rsp_id_l), 1);
        check("t6_status", 32'(rsp_st_l), 32'(ST_OK));

        tick(2);
        check("protocol_viol", 32'(viol), 0);
        check("operand_stable", 32'(stab_err), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
